// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame size and command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS = 10;
  localparam int unsigned PS2_IDX_W      = 4;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  // Outbound frame after the start bit: data LSB first, odd parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-flop synchronizer, stability filter and a falling-edge pulse.
module ps2_line_filter #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int unsigned CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A new level is taken only after FILTER_CYCLES consecutive differing samples.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
        level_d = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving the open-drain clock/data pair.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_CYCLES  = 8
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [PS2_IDX_W-1:0]      idx_q, idx_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic                      clk_oe_q, clk_oe_d;
  logic                      data_oe_q, data_oe_d;
  logic                      ready_q, ready_d;
  logic                      busy_q;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      timeout;

  logic clk_level, clk_fall;
  logic data_level, data_fall_unused;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
    .clk     (board_clk),
    .rst_n   (reset),
    .line_in (ps2_clk_in),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filt (
    .clk     (board_clk),
    .rst_n   (reset),
    .line_in (ps2_data_in),
    .level   (data_level),
    .fall    (data_fall_unused)
  );

  assign cnt_inc = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Next state; pin enables and result pulses are computed for the following cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    idx_d     = idx_q;
    frame_d   = frame_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d  = ps2_frame(tx_data);
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        data_oe_d = 1'b1;
        idx_d     = '0;
        cnt_d     = '0;
        state_d   = SEND;
      end
      SEND: begin
        if (timeout) begin
          err_d     = 1'b1;
          data_oe_d = 1'b0;
          state_d   = WAIT_IDLE;
        end else if (clk_fall) begin
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + PS2_IDX_W'(1);
          if (idx_q == PS2_IDX_W'(PS2_FRAME_BITS - 1)) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        data_oe_d = 1'b0;
        if (timeout) begin
          err_d   = 1'b1;
          state_d = WAIT_IDLE;
        end else if (clk_fall) begin
          done_d  = ~data_level;
          err_d   = data_level;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        data_oe_d = 1'b0;
        if (clk_level && data_level) begin
          state_d = IDLE;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= ~ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
